// File: rtl/pipelined_counter_bank_pkg.sv
// Shared types and parameter helpers for the pipelined counter bank.
package pipelined_counter_bank_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} count_mode_e;

    localparam int unsigned MinWidth    = 2;
    localparam int unsigned MinChannels = 1;
    localparam int unsigned MinDepth    = 1;

    // Warm-up counter must be able to hold the value DEPTH.
    function automatic int unsigned warm_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter with sticky overflow flag and a DEPTH-stage sampling delay line.
module counter_channel
    import pipelined_counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1,
    parameter count_mode_e MODE  = CNT_WRAP,
    parameter int unsigned INIT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] sample,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_comb begin
        sum     = {1'b0, count_q} + {1'b0, step};
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (sum[WIDTH]) begin
                ovf_d   = 1'b1;
                count_d = (MODE == CNT_SAT) ? '1 : sum[WIDTH-1:0];
            end else begin
                count_d = sum[WIDTH-1:0];
            end
        end
    end

    // Stage 0 captures the pre-edge count, so sample lags count by exactly DEPTH edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= InitVal;
            ovf_q   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= InitVal;
            end
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            stage_q[0] <= count_q;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign count  = count_q;
    assign sample = stage_q[DEPTH-1];
    assign ovf    = ovf_q;

endmodule

// File: rtl/pipelined_counter_bank.sv
// Bank of independent counters, each sampled through a delay line, with a shared
// warm-up tracker that flags when the delay lines hold real history.
module pipelined_counter_bank
    import pipelined_counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 1,
    parameter count_mode_e MODE     = CNT_WRAP,
    parameter int unsigned INIT     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0]          step,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS*WIDTH-1:0] sample,
    output logic                      sample_vld,
    output logic [CHANNELS-1:0]       ovf
);

    if (WIDTH < MinWidth) begin : g_bad_width
        $error("pipelined_counter_bank: WIDTH must be >= 2");
    end
    if (CHANNELS < MinChannels) begin : g_bad_channels
        $error("pipelined_counter_bank: CHANNELS must be >= 1");
    end
    if (DEPTH < MinDepth) begin : g_bad_depth
        $error("pipelined_counter_bank: DEPTH must be >= 1");
    end

    localparam int unsigned      WarmW   = warm_width(DEPTH);
    localparam logic [WarmW-1:0] WarmMax = WarmW'(DEPTH);

    logic [WarmW-1:0] warm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= '0;
        end else if (warm_q != WarmMax) begin
            warm_q <= warm_q + WarmW'(1);
        end
    end

    assign sample_vld = (warm_q == WarmMax);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        counter_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .MODE  (MODE),
            .INIT  (INIT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[i]),
            .clr      (clr[i]),
            .load     (load[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .step     (step),
            .count    (count[i*WIDTH +: WIDTH]),
            .sample   (sample[i*WIDTH +: WIDTH]),
            .ovf      (ovf[i])
        );
    end

endmodule

// File: tb/tb_pipelined_counter_bank.sv
// Scoreboard bench: a wrapping DEPTH=1 bank and a saturating DEPTH=3 bank share stimulus.
module tb_pipelined_counter_bank;
    import pipelined_counter_bank_pkg::*;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int IV = 1;

    typedef struct packed {
        logic [CH*W-1:0] cw, sw, cs, ss;
        logic [CH-1:0]   ow, os;
        logic            vw, vs;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [CH-1:0]   en = '0, clr = '0, load = '0;
    logic [CH*W-1:0] load_val = '0;
    logic [W-1:0]    step = '0;

    logic [CH*W-1:0] count_w, sample_w, count_s, sample_s;
    logic [CH-1:0]   ovf_w, ovf_s;
    logic            vld_w, vld_s;

    pipelined_counter_bank #(
        .WIDTH(W), .CHANNELS(CH), .DEPTH(1), .MODE(CNT_WRAP), .INIT(IV)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .step(step), .count(count_w), .sample(sample_w), .sample_vld(vld_w), .ovf(ovf_w)
    );

    pipelined_counter_bank #(
        .WIDTH(W), .CHANNELS(CH), .DEPTH(3), .MODE(CNT_SAT), .INIT(IV)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .step(step), .count(count_s), .sample(sample_s), .sample_vld(vld_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    // Reference model: integer counters plus a history of every post-edge count vector.
    int unsigned     mcnt [2][CH];
    bit              movf [2][CH];
    int              medges;
    logic [2*CH*W-1:0] hist[$];
    exp_t            expq[$];
    int              nchecks = 0;
    int              nerr = 0;

    function automatic int dep(input int m);
        return (m == 0) ? 1 : 3;
    endfunction

    function automatic logic [CH*W-1:0] pack_counts(input int m);
        logic [CH*W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*W +: W] = W'(mcnt[m][c]);
        return v;
    endfunction

    function automatic logic [CH*W-1:0] init_vec();
        logic [CH*W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*W +: W] = W'(IV);
        return v;
    endfunction

    function automatic logic [CH*W-1:0] model_sample(input int m);
        logic [2*CH*W-1:0] h;
        if (medges < dep(m)) return init_vec();
        h = hist[medges - dep(m)];
        return (m == 0) ? h[CH*W-1:0] : h[2*CH*W-1:CH*W];
    endfunction

    function automatic logic [CH-1:0] pack_ovf(input int m);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = movf[m][c];
        return v;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.cw = pack_counts(0);
        e.cs = pack_counts(1);
        e.sw = model_sample(0);
        e.ss = model_sample(1);
        e.ow = pack_ovf(0);
        e.os = pack_ovf(1);
        e.vw = (medges >= dep(0));
        e.vs = (medges >= dep(1));
        expq.push_back(e);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < CH; c++) begin
                mcnt[m][c] = IV;
                movf[m][c] = 1'b0;
            end
        medges = 0;
        hist.delete();
        hist.push_back({pack_counts(1), pack_counts(0)});
        push_exp();
    endtask

    task automatic model_edge();
        int unsigned s;
        int unsigned maxv;
        maxv = (1 << W) - 1;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < CH; c++) begin
                if (clr[c]) begin
                    mcnt[m][c] = 0;
                    movf[m][c] = 1'b0;
                end else if (load[c]) begin
                    mcnt[m][c] = load_val[c*W +: W];
                end else if (en[c]) begin
                    s = mcnt[m][c] + step;
                    if (s > maxv) begin
                        movf[m][c] = 1'b1;
                        mcnt[m][c] = (m == 0) ? s - (maxv + 1) : maxv;
                    end else begin
                        mcnt[m][c] = s;
                    end
                end
            end
        medges++;
        hist.push_back({pack_counts(1), pack_counts(0)});
        push_exp();
    endtask

    always @(posedge clk) if (rst_n) model_edge();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after each edge or async reset, compare everything the model queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (expq.size() > 0) begin
                e = expq.pop_front();
                chk("count_wrap",  count_w,  e.cw);
                chk("sample_wrap", sample_w, e.sw);
                chk("ovf_wrap",    32'(ovf_w), 32'(e.ow));
                chk("vld_wrap",    32'(vld_w), 32'(e.vw));
                chk("count_sat",   count_s,  e.cs);
                chk("sample_sat",  sample_s, e.ss);
                chk("ovf_sat",     32'(ovf_s), 32'(e.os));
                chk("vld_sat",     32'(vld_s), 32'(e.vs));
            end
        end
    end

    task automatic drive(input logic [CH-1:0] e, input logic [CH-1:0] c, input logic [CH-1:0] l,
                         input logic [CH*W-1:0] lv, input logic [W-1:0] s);
        @(negedge clk);
        en = e; clr = c; load = l; load_val = lv; step = s;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Channel 0 counts by 1, others hold.
        repeat (4) drive(4'b0001, '0, '0, '0, 8'd1);
        // Wrap across 0xFF with step 1; saturate in the DEPTH=3 bank.
        drive('0, '0, 4'b0001, 32'h0000_00FE, 8'd0);
        repeat (3) drive(4'b0001, '0, '0, '0, 8'd1);
        drive(4'b0001, '0, '0, '0, 8'd0);
        drive('0, 4'b0001, '0, '0, 8'd0);
        // Step 3 from 0xFE, then step 0 with en.
        drive('0, '0, 4'b0001, 32'h0000_00FE, 8'd0);
        repeat (2) drive(4'b0001, '0, '0, '0, 8'd3);
        repeat (2) drive(4'b0001, '0, '0, '0, 8'd0);
        // Priority: ch0 clr+load+en, ch1 load+en.
        drive(4'b1111, 4'b0001, 4'b0011, 32'h4040_4040, 8'd1);
        // Sample continuity across a clear.
        repeat (3) drive(4'b1111, '0, '0, '0, 8'd5);
        drive(4'b1111, 4'b0110, '0, '0, 8'd5);
        repeat (4) drive(4'b1111, '0, '0, '0, 8'd7);

        reset_pulse();
        repeat (3) drive(4'b1010, '0, '0, '0, 8'd9);

        for (int n = 0; n < 600; n++) begin
            logic [CH-1:0]   c, l;
            logic [CH*W-1:0] lv;
            logic [W-1:0]    s;
            for (int k = 0; k < CH; k++) begin
                c[k] = ($urandom_range(15) == 0);
                l[k] = ($urandom_range(9) == 0);
                lv[k*W +: W] = W'($urandom);
            end
            case ($urandom_range(3))
                0:       s = '0;
                1:       s = W'($urandom_range(4));
                default: s = W'($urandom);
            endcase
            drive(CH'($urandom), c, l, lv, s);
            if (n == 300) reset_pulse();
        end

        drive('0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/pipelined_counter_bank.md
# pipelined_counter_bank

Bank of CHANNELS independent WIDTH-bit counters sharing one clock edge, each paired with a sampler that reads its counter through a DEPTH-stage delay line. All state updates with nonblocking semantics, so the sampled value is deterministic regardless of process ordering: a sample always reflects the counter value from before the same edge. Used as the reference counter/sampler primitive for clocked examples and as a self-checking stimulus source for benches.

## Interface
- WIDTH, 8: counter and sample width in bits (>= 2)
- CHANNELS, 4: number of independent counter/sampler channels (>= 1)
- DEPTH, 1: sampler delay-line stages (>= 1)
- MODE, CNT_WRAP: overflow behaviour, CNT_WRAP or CNT_SAT
- INIT, 1: reset value of every counter and every delay-line stage

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  CHANNELS  per-channel increment enable
- clr  in  CHANNELS  per-channel synchronous clear
- load  in  CHANNELS  per-channel synchronous load
- load_val  in  CHANNELS*WIDTH  load values, channel i at bits [i*WIDTH +: WIDTH]
- step  in  WIDTH  increment amount, shared by all channels
- count  out  CHANNELS*WIDTH  current counter values
- sample  out  CHANNELS*WIDTH  counter values delayed DEPTH edges
- sample_vld  out  1  high once DEPTH edges have occurred since reset
- ovf  out  CHANNELS  sticky overflow flag per channel

## Operation
- Per channel, per edge, priority clr > load > en > hold.
- clr: count <= 0, ovf <= 0.
- load: count <= load_val slice; ovf unchanged.
- en: sum = {1'b0,count} + {1'b0,step}, computed WIDTH+1 bits wide; carry = sum[WIDTH].
  - CNT_WRAP: count <= sum[WIDTH-1:0].
  - CNT_SAT: count <= carry ? all-ones : sum[WIDTH-1:0].
  - carry sets ovf (sticky until clr or reset).
- step = 0 with en: count holds, no ovf.
- Delay line: stage0 <= count (pre-edge value); stage k <= stage k-1; sample = stage DEPTH-1. Hence sample(t) = count(t-DEPTH).
- clr and load do not flush the delay line.
- sample_vld: warm-up counter of ceil(log2(DEPTH+1)) bits, saturating at DEPTH; sample_vld = (warm-up == DEPTH).
- Channels fully independent; simultaneous events on different channels never interact.

## Timing
- Reset values (asserted immediately on rst_n falling, no clock required): count = INIT, every delay stage and sample = INIT, ovf = 0, sample_vld = 0, warm-up = 0.
- Reset release: first active edge is the first posedge with rst_n high.
- Control-to-count latency: 1 edge. Control-to-sample latency: DEPTH+1 edges.
- ovf visible the same edge count wraps/saturates.
- sample_vld rises on the DEPTH-th edge after reset release and stays high.
- Reset mid-operation discards all in-flight delay-line contents.

## Structure
- Package pipelined_counter_bank_pkg: typedef enum count_mode_e {CNT_WRAP, CNT_SAT}; shared parameter range checks as localparams/functions.
- Sub-module counter_channel (one counter, ovf flag, delay line) instantiated CHANNELS times via generate; the warm-up counter and sample_vld live in the top.
- Elaboration-time assertions on WIDTH >= 2, CHANNELS >= 1, DEPTH >= 1.

## Test plan
- WIDTH=8, DEPTH=1, INIT=1, en[0]=1, step=1 after reset -> count0 = 2,3,4,... on successive edges; sample0 = 1,2,3,... (one edge behind); other channels hold 1.
- CNT_WRAP, load 0xFE then en with step=1 -> count0 0xFF, 0x00, 0x01; ovf0 rises with 0x00 and stays high until clr.
- CNT_SAT, load 0xFE then en with step=3 -> count0 0xFF and holds; ovf0 = 1; step=0 with en -> no change.
- Same edge clr+load+en -> count 0, ovf 0; load+en with load_val 0x40 -> count 0x40 (en ignored).
- DEPTH=3 -> sample_vld low for 2 edges, high from 3rd; sample equals count from 3 edges earlier, including across a clr.
- rst_n pulsed low between edges mid-count -> count, sample = INIT, ovf = 0, sample_vld = 0 immediately, before the next posedge.
